bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial stage upstream of the 1101 Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_out, which drives the detector's serial input.
- Supports optional inter-word idle gaps and a selectable bit order, so benches and upstream logic can produce controlled bit streams, including runs that straddle word boundaries.

Parameters:
WIDTH, 8, word width in bits (>=2)
GAP, 0, idle cycles inserted after each word (0 = back-to-back streaming)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 0, ser_out level whenever no word bit is being driven

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  WIDTH  parallel word; sampled only on an accepted handshake
data_valid  input  1  upstream has a word on data_in
data_ready  output  1  block can accept a word this cycle (combinational from state)
ser_out  output  1  serial bit to detector (registered)
ser_valid  output  1  ser_out carries a word bit this cycle (registered)
frame_done  output  1  one-cycle pulse coincident with the last bit of a word (registered)
busy  output  1  state != IDLE (registered)
word_cnt  output  16  count of completed words; wraps 16'hFFFF -> 0

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, ser_out=IDLE_BIT, ser_valid=0, frame_done=0, busy=0, word_cnt=0, bit and gap counters cleared.
  - data_ready forced 0 while rst=1.
- States:
  - IDLE: no word in flight.
  - SHIFT: driving bits; bit_cnt runs 0..WIDTH-1.
  - GAP: idle spacing; gap_cnt runs 0..GAP-1; only entered when GAP>0.
- data_ready is 1 when any of:
  - state=IDLE;
  - state=SHIFT, bit_cnt=WIDTH-1 and GAP=0;
  - state=GAP and gap_cnt=GAP-1.
- Accept = data_valid & data_ready. On accept, data_in is loaded into the shift register.
- Latency: the first bit appears on ser_out with ser_valid=1 on the cycle after the accept edge.
- Bit order:
  - MSB_FIRST=1: data_in[WIDTH-1] first, data_in[0] last.
  - MSB_FIRST=0: the reverse.
- SHIFT:
  - One bit per cycle, exactly WIDTH cycles, ser_valid=1 throughout.
  - frame_done=1 and word_cnt increments during the cycle ser_out carries the last bit.
- After the last bit:
  - Accept on that cycle (GAP=0 only): the next word's first bit follows with no bubble; state stays SHIFT.
  - Else if GAP>0: go to GAP.
  - Else: go to IDLE.
- GAP: ser_out=IDLE_BIT, ser_valid=0 for exactly GAP cycles.
  - Accept on the last gap cycle: go to SHIFT.
  - Otherwise: go to IDLE.
- IDLE: ser_out=IDLE_BIT, ser_valid=0, frame_done=0. Remains until accept.
- data_in and data_valid are ignored when data_ready=0. A word is never dropped or duplicated; a valid held without ready waits.
- Reset mid-word: the word in flight is discarded and word_cnt is not incremented. The cycle after the reset edge shows reset values. data_ready=1 on the first cycle with rst=0.
- Simultaneous rst and accept: rst wins; the word is not taken.

Test Plan:
1. WIDTH=8, GAP=0, MSB_FIRST=1; accept 8'hD5 at cycle 0 -> ser_out 1,1,0,1,0,1,0,1 on cycles 1..8; ser_valid=1 on cycles 1..8 only; frame_done only at cycle 8; word_cnt=1; downstream detector out=1 at cycle 4.
2. Back-to-back, GAP=0: data_valid held with 8'hDD then 8'h0D -> 16 contiguous valid bits 11011101_00001101; data_ready=1 only at the idle cycle and cycle 8; frame_done at cycles 8 and 16; word_cnt=2.
3. GAP=2, words 8'hF0 then 8'h0F continuously offered -> 8 bits, 2 cycles ser_valid=0 with ser_out=IDLE_BIT, then 8 bits; second accept occurs on cycle 10.
4. MSB_FIRST=0, accept 8'h0B -> ser_out 1,1,0,1,0,0,0,0.
5. Reset mid-word: accept 8'hAA, assert rst for 1 cycle after the 3rd bit -> next cycle ser_valid=0, ser_out=IDLE_BIT, busy=0, word_cnt=0. A subsequent 8'h5A transmits fully; word_cnt=1.
6. data_valid=0 for 20 cycles from IDLE -> data_ready=1, ser_valid=0, word_cnt unchanged. Preload word_cnt path by streaming 65536 words (or force) -> wraps to 0.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage feeding the 1101 sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// ser_out, with optional idle gap cycles between words.
//
// Handshake: a word is taken on a rising edge where data_valid and data_ready
// are both 1. data_ready depends only on state and rst, never on data_valid.
// Upstream must hold data_in stable while data_valid=1 and data_ready=0.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      word_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] shreg;   // bits still to send, next one at the output end
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  assign dbg_state = state;

  // Ready to take a word when idle or on the final cycle of a word/gap.
  always_comb begin
    data_ready = 1'b0;
    if (!rst) begin
      if (state == S_IDLE)
        data_ready = 1'b1;
      else if (state == S_SHIFT && bit_cnt == BIT_LAST && GAP == 0)
        data_ready = 1'b1;
      else if (state == S_GAP && gap_cnt == GAP_LAST)
        data_ready = 1'b1;
    end
  end

  assign accept = data_valid & data_ready;

  // Bit-order selection: which bit goes out first and how the rest advance.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = data_in[WIDTH-1];
      load_rest  = data_in << 1;
      next_bit   = shreg[WIDTH-1];
      shift_rest = shreg << 1;
    end else begin
      first_bit  = data_in[0];
      load_rest  = data_in >> 1;
      next_bit   = shreg[0];
      shift_rest = shreg >> 1;
    end
  end

  // Sequencer: shift bits, run gap spacing, count words; an accept overrides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      word_cnt   <= 16'd0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ser_out <= next_bit;
            shreg   <= shift_rest;
            bit_cnt <= bit_cnt + BW'(1);
            // The bit going out next is the word's last one.
            if (bit_cnt == BIT_PEN) begin
              frame_done <= 1'b1;
              word_cnt   <= word_cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_IDLE: ;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // A new word starts on the next cycle regardless of where we were.
      if (accept) begin
        state     <= S_SHIFT;
        busy      <= 1'b1;
        ser_out   <= first_bit;
        ser_valid <= 1'b1;
        shreg     <= load_rest;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: three serializer configurations run side by side, each
// checked every cycle against a bit-queue model plus a word scoreboard.
module tb_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : cfg
    localparam int G  = (gi == 1) ? 2 : 0;
    localparam bit M  = (gi == 2) ? 1'b0 : 1'b1;
    localparam bit IB = (gi == 1) ? 1'b1 : 1'b0;

    logic         rst, dv;
    logic [W-1:0] din;
    logic         rdy, so, sv, fd, bz;
    logic [15:0]  wc;
    logic [1:0]   st;
    logic         fin = 1'b0;

    // model: bits still to appear (front = bit on ser_out now), gap cycles left
    bit           mq[$];
    int           gap_left;
    logic [15:0]  wcnt;
    bit           took;
    // scoreboard: accepted words awaiting reassembly from the serial stream
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx;

    bit_serializer #(.WIDTH(W), .GAP(G), .MSB_FIRST(M), .IDLE_BIT(IB)) dut (
      .clk(clk), .rst(rst), .data_in(din), .data_valid(dv),
      .data_ready(rdy), .ser_out(so), .ser_valid(sv), .frame_done(fd),
      .busy(bz), .word_cnt(wc), .dbg_state(st)
    );

    function automatic string tg(input string s);
      return $sformatf("c%0d_%s", gi, s);
    endfunction

    function automatic bit exp_ready();
      if (rst) return 1'b0;
      return (mq.size() == 0 && gap_left == 0) ||
             (mq.size() == 1 && G == 0) || (gap_left == 1);
    endfunction

    task automatic check_outputs();
      bit active = (mq.size() > 0);
      check(tg("ready"), 32'(rdy), 32'(exp_ready()));
      check(tg("ser_valid"), 32'(sv), 32'(active));
      check(tg("ser_out"), 32'(so), 32'(active ? mq[0] : IB));
      check(tg("frame_done"), 32'(fd), 32'(mq.size() == 1));
      check(tg("busy"), 32'(bz), 32'(active || gap_left > 0));
      check(tg("state_nonidle"), 32'(st != 2'd0), 32'(active || gap_left > 0));
      check(tg("word_cnt"), 32'(wc), 32'(wcnt));
      if (sv) rx = M ? {rx[W-2:0], so} : {so, rx[W-1:1]};
      if (fd) begin
        if (exp_q.size() == 0) check(tg("word_extra"), 32'(rx), 32'hFFFF_FFFF);
        else check(tg("word"), 32'(rx), 32'(exp_q.pop_front()));
      end
    endtask

    task automatic model_step();
      took = !rst && dv && exp_ready();
      if (rst) begin
        mq.delete();
        exp_q.delete();
        gap_left = 0;
        wcnt = 16'd0;
      end else begin
        if (mq.size() > 0) begin
          void'(mq.pop_front());
          if (mq.size() == 1) wcnt = wcnt + 16'd1;
          if (mq.size() == 0) gap_left = G;
        end else if (gap_left > 0) begin
          gap_left--;
        end
        if (took) begin
          gap_left = 0;
          exp_q.push_back(din);
          for (int i = 0; i < W; i++) mq.push_back(M ? din[W-1-i] : din[i]);
        end
      end
    endtask

    // driver: one clock cycle with the given inputs
    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
      rst = r; dv = v; din = d;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
    endtask

    task automatic send(input logic [W-1:0] d);
      int n = 0;
      do begin
        cyc(1'b0, 1'b1, d);
        n++;
      end while (!took && n < 64);
      check(tg("accepted"), 32'(took), 32'd1);
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
      rst = 1'b1; dv = 1'b0; din = '0; rx = '0;
      gap_left = 0; wcnt = 16'd0;
      @(posedge clk);
      model_step();
      #1;
      cyc(1'b1, 1'b0, '0);
      idle(20);
      send(8'hD5); idle(12);
      send(8'hDD); send(8'h0D); idle(12);
      send(8'hF0); send(8'h0F); idle(12);
      send(8'h0B); idle(12);
      // reset after the third bit of a word, then reset colliding with a word
      send(8'hAA); idle(3);
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 8'h5A);
      send(8'h5A); idle(12);
      // preload the word counter near its wrap point while idle
      force dut.word_cnt = 16'hFFFE;
      wcnt = 16'hFFFE;
      cyc(1'b0, 1'b0, '0);
      release dut.word_cnt;
      send(8'h33); send(8'h44); idle(12);
      check(tg("wrap"), 32'(wc), 32'd0);
      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++)
        cyc(1'b0 || ($urandom_range(0, 99) == 0), $urandom_range(0, 2) != 0, W'($urandom));
      idle(12);
      fin = 1'b1;
    end
  end

  // final report
  initial begin
    int t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: stimulus incomplete after %0d cycles", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
